memory_stage: RTL

- Pipeline stage directly downstream of the execute stage.
- Consumes the execute pipeline-register outputs and performs load/store accesses to the data memory over a req/ready handshake.
- Aligns and sign/zero-extends load data, then registers results into the memory→writeback pipeline register.
- Asserts a stall to freeze upstream stages while a multi-cycle access is outstanding.

---
 rtl/memory_stage.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: handles loads/stores over a req/ready handshake and feeds the MEM/WB register.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module memory_stage #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [2:0]            i_result_src,
  input  logic                  i_mem_we,
  input  logic                  i_reg_we,
  input  logic                  i_load_instr,
  input  logic [2:0]            i_func3,
  input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
  input  logic [ADDR_WIDTH-1:0] i_pc_target,
  input  logic [DATA_WIDTH-1:0] i_imm_ext,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [7:0]            o_mem_wstrb,
  input  logic                  i_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_stall_mem,
  output logic                  o_misaligned,
`ifdef MEM_TIMEOUT_EN
  output logic                  o_mem_fault,
`endif
  output logic [2:0]            o_result_src,
  output logic                  o_reg_we,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4,
  output logic [ADDR_WIDTH-1:0] o_pc_target,
  output logic [DATA_WIDTH-1:0] o_imm_ext,
  output logic [DATA_WIDTH-1:0] o_alu_result,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [REG_ADDR_W-1:0] o_rd_addr_fwd,
  output logic                  o_reg_we_fwd
);

  if (DATA_WIDTH != 64 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("memory_stage: DATA_WIDTH must be 64 and TIMEOUT_CYCLES positive");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e                state_q, state_d;
  logic                  mem_op, misalign, start, access_end, pipe_load, drop_we, fault, timeout;
  logic [2:0]            off;
  logic [7:0]            strb_base;
  logic [DATA_WIDTH-1:0] rdata_q, shifted, load_ext;

  assign mem_op = i_load_instr | i_mem_we;
  assign off    = i_alu_result[2:0];

  // Store sizes 4-7 do not exist, so they are rejected the same way as a misaligned access.
  always_comb begin
    misalign = 1'b0;
    case (i_func3[1:0])
      2'd1:    misalign = off[0];
      2'd2:    misalign = |off[1:0];
      2'd3:    misalign = |off;
      default: misalign = 1'b0;
    endcase
    if (i_mem_we && i_func3[2]) misalign = 1'b1;
  end

  assign start        = (state_q == IDLE) && mem_op && !misalign;
  assign access_end   = (state_q == ACCESS) && (i_mem_ready || timeout);
  assign pipe_load    = ((state_q == IDLE) && !start) || (state_q == DONE);
  assign o_stall_mem  = i_arst && (start || (state_q == ACCESS));
  assign o_misaligned = i_arst && (state_q == IDLE) && mem_op && misalign;

  assign o_rd_addr_fwd = i_rd_addr;
  assign o_reg_we_fwd  = i_reg_we;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          fault_q;

  assign timeout     = (state_q == ACCESS) && !i_mem_ready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign fault       = fault_q;
  assign o_mem_fault = fault_q;

  // fault_q is set on the ACCESS->DONE timeout edge, so it is high exactly for the DONE cycle.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
      if (timeout)                fault_q <= 1'b1;
      else if (state_q == DONE)   fault_q <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCESS;
      ACCESS:  if (access_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    strb_base = 8'h00;
    case (i_func3[1:0])
      2'd0: strb_base = 8'h01;
      2'd1: strb_base = 8'h03;
      2'd2: strb_base = 8'h0F;
      2'd3: strb_base = 8'hFF;
      default: strb_base = 8'h00;
    endcase
  end

  assign shifted = rdata_q >> {off, 3'b000};

  always_comb begin
    load_ext = '0;
    case (i_func3)
      3'd0: load_ext = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
      3'd1: load_ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'd2: load_ext = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
      3'd3: load_ext = shifted;
      3'd4: load_ext = {{(DATA_WIDTH-8){1'b0}},  shifted[7:0]};
      3'd5: load_ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      3'd6: load_ext = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
      default: load_ext = '0;
    endcase
  end

  assign drop_we = (mem_op && misalign) || (i_load_instr && (i_func3 == 3'd7)) || fault;

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q     <= IDLE;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        o_mem_req   <= 1'b1;
        o_mem_we    <= i_mem_we;
        o_mem_addr  <= {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
        o_mem_wdata <= i_write_data << {off, 3'b000};
        o_mem_wstrb <= i_mem_we ? (strb_base << off) : 8'h00;
      end else if (access_end) begin
        o_mem_req <= 1'b0;
        o_mem_we  <= 1'b0;
      end
      if ((state_q == ACCESS) && i_mem_ready) rdata_q <= i_mem_rdata;
    end
  end

  // While stalled the writeback register carries a bubble (reg_we low) instead of replaying.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      o_result_src <= '0;
      o_reg_we     <= 1'b0;
      o_pc_plus4   <= '0;
      o_pc_target  <= '0;
      o_imm_ext    <= '0;
      o_alu_result <= '0;
      o_read_data  <= '0;
      o_rd_addr    <= '0;
    end else if (pipe_load) begin
      o_result_src <= i_result_src;
      o_reg_we     <= i_reg_we && !drop_we;
      o_pc_plus4   <= i_pc_plus4;
      o_pc_target  <= i_pc_target;
      o_imm_ext    <= i_imm_ext;
      o_alu_result <= i_alu_result;
      o_read_data  <= ((state_q == DONE) && i_load_instr && !fault) ? load_ext : '0;
      o_rd_addr    <= i_rd_addr;
    end else begin
      o_reg_we <= 1'b0;
    end
  end

endmodule
